// File: rtl/tft_timing_ctrl.sv
`default_nettype none
// tft_timing_ctrl: 480x272 RGB565 raster timing, pixel request and panel data path.
// Revision 1.0
module tft_timing_ctrl #(
  parameter logic [10:0] H_SYNC  = 11'd41,
  parameter logic [10:0] H_BACK  = 11'd2,
  parameter logic [10:0] H_VALID = 11'd480,
  parameter logic [10:0] H_FRONT = 11'd2,
  parameter logic [10:0] H_TOTAL = 11'd525,
  parameter logic [10:0] V_SYNC  = 11'd10,
  parameter logic [10:0] V_BACK  = 11'd2,
  parameter logic [10:0] V_VALID = 11'd272,
  parameter logic [10:0] V_FRONT = 11'd2,
  parameter logic [10:0] V_TOTAL = 11'd286
) (
  input  logic        tft_clk_9m,
  input  logic        sys_rst_n,
  input  logic [15:0] pix_data,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic [15:0] rgb_tft,
  output logic        hsync,
  output logic        vsync,
  output logic        tft_clk,
  output logic        tft_de,
  output logic        tft_bl,
  output logic        frame_start
);

  localparam logic [10:0] c_H_ACT_START = H_SYNC + H_BACK;
  localparam logic [10:0] c_H_ACT_END   = c_H_ACT_START + H_VALID;
  localparam logic [10:0] c_H_REQ_START = c_H_ACT_START - 11'd1;
  localparam logic [10:0] c_H_REQ_END   = c_H_ACT_END - 11'd1;
  localparam logic [10:0] c_H_LAST      = H_TOTAL - 11'd1;
  localparam logic [10:0] c_V_ACT_START = V_SYNC + V_BACK;
  localparam logic [10:0] c_V_ACT_END   = c_V_ACT_START + V_VALID;
  localparam logic [10:0] c_V_LAST      = V_TOTAL - 11'd1;
  localparam logic [10:0] c_PIX_IDLE    = 11'h3FF;

  if ((H_SYNC + H_BACK + H_VALID + H_FRONT) != H_TOTAL) begin : g_h_total_check
    $error("tft_timing_ctrl: horizontal timing does not sum to H_TOTAL");
  end

  if ((V_SYNC + V_BACK + V_VALID + V_FRONT) != V_TOTAL) begin : g_v_total_check
    $error("tft_timing_ctrl: vertical timing does not sum to V_TOTAL");
  end

  logic [10:0] r_cnt_h;
  logic [10:0] r_cnt_v;
  logic        w_h_last;
  logic        w_v_last;
  logic        w_h_act;
  logic        w_v_act;
  logic        w_h_req;
  logic        w_pix_req;

  assign w_h_last = (r_cnt_h == c_H_LAST);
  assign w_v_last = (r_cnt_v == c_V_LAST);

  always_ff @(posedge tft_clk_9m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt_h <= 11'd0;
    end else if (w_h_last) begin
      r_cnt_h <= 11'd0;
    end else begin
      r_cnt_h <= r_cnt_h + 11'd1;
    end
  end

  always_ff @(posedge tft_clk_9m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt_v <= 11'd0;
    end else if (w_h_last) begin
      if (w_v_last) begin
        r_cnt_v <= 11'd0;
      end else begin
        r_cnt_v <= r_cnt_v + 11'd1;
      end
    end
  end

  assign w_h_act = (r_cnt_h >= c_H_ACT_START) && (r_cnt_h < c_H_ACT_END);
  assign w_v_act = (r_cnt_v >= c_V_ACT_START) && (r_cnt_v < c_V_ACT_END);

  // Requests lead the display window by one clock to cover the generator's output register.
  assign w_h_req   = (r_cnt_h >= c_H_REQ_START) && (r_cnt_h < c_H_REQ_END);
  assign w_pix_req = w_h_req && w_v_act;

  assign pix_x = w_pix_req ? (r_cnt_h - c_H_REQ_START) : c_PIX_IDLE;
  assign pix_y = w_pix_req ? (r_cnt_v - c_V_ACT_START) : c_PIX_IDLE;

  assign hsync   = (r_cnt_h < H_SYNC);
  assign vsync   = (r_cnt_v < V_SYNC);
  assign tft_de  = w_h_act && w_v_act;
  assign rgb_tft = tft_de ? pix_data : 16'h0000;

  assign tft_clk     = tft_clk_9m;
  assign tft_bl      = sys_rst_n;
  assign frame_start = sys_rst_n && (r_cnt_h == 11'd0) && (r_cnt_v == 11'd0);

endmodule
`default_nettype wire

// File: tb/tb_tft_timing_ctrl.sv
`default_nettype none
// tb_tft_timing_ctrl: directed checks of raster timing, request window and data path.
// Revision 1.0
module tb_tft_timing_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pix_data = 16'h0;
  logic        gen_const = 1'b0;

  logic [10:0] pix_x, pix_y;
  logic [15:0] rgb_tft;
  logic        hsync, vsync, tft_clk, tft_de, tft_bl, frame_start;

  logic [10:0] s_pix_x, s_pix_y;
  logic [15:0] s_rgb;
  logic        s_hsync, s_vsync, s_tft_clk, s_de, s_bl, s_fs;

  int t;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Clocks elapsed since reset release; equals cnt_v*H_TOTAL + cnt_h within a frame.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t <= 0;
    else        t <= t + 1;
  end

  tft_timing_ctrl u_dut (
    .tft_clk_9m (clk),
    .sys_rst_n  (rst_n),
    .pix_data   (pix_data),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .rgb_tft    (rgb_tft),
    .hsync      (hsync),
    .vsync      (vsync),
    .tft_clk    (tft_clk),
    .tft_de     (tft_de),
    .tft_bl     (tft_bl),
    .frame_start(frame_start)
  );

  // Scaled-down raster (16 clocks x 8 lines) so whole frames fit in a short run.
  tft_timing_ctrl #(
    .H_SYNC(11'd4), .H_BACK(11'd2), .H_VALID(11'd8), .H_FRONT(11'd2), .H_TOTAL(11'd16),
    .V_SYNC(11'd2), .V_BACK(11'd1), .V_VALID(11'd4), .V_FRONT(11'd1), .V_TOTAL(11'd8)
  ) u_small (
    .tft_clk_9m (clk),
    .sys_rst_n  (rst_n),
    .pix_data   (16'hABCD),
    .pix_x      (s_pix_x),
    .pix_y      (s_pix_y),
    .rgb_tft    (s_rgb),
    .hsync      (s_hsync),
    .vsync      (s_vsync),
    .tft_clk    (s_tft_clk),
    .tft_de     (s_de),
    .tft_bl     (s_bl),
    .frame_start(s_fs)
  );

  function automatic logic [15:0] bar_colour(input logic [10:0] x);
    case (x / 11'd48)
      11'd0:   return 16'hF800;
      11'd1:   return 16'hFC00;
      11'd2:   return 16'hFFE0;
      11'd3:   return 16'h07E0;
      11'd4:   return 16'h07FF;
      11'd5:   return 16'h001F;
      11'd6:   return 16'hF81F;
      11'd7:   return 16'hFFFF;
      11'd8:   return 16'h8410;
      11'd9:   return 16'hD69A;
      default: return 16'h0000;
    endcase
  endfunction

  // Colour-bar pixel generator with its one-cycle output register.
  always @(posedge clk) begin
    if (gen_const)               pix_data <= 16'h1234;
    else if (pix_x == 11'h3FF)   pix_data <= 16'h0000;
    else                         pix_data <= bar_colour(pix_x);
  end

  task automatic goto(input int target);
    int guard = 0;
    while (t != target && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (t != target) begin
      errors++;
      $display("FAIL goto: position %0d, required %0d", t, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({hsync, vsync, tft_de, tft_bl, frame_start} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_ctrl: {hs,vs,de,bl,fs}=%b required 11000",
               {hsync, vsync, tft_de, tft_bl, frame_start});
    end
    checks++;
    if (pix_x !== 11'h3FF || pix_y !== 11'h3FF) begin
      errors++;
      $display("FAIL reset_pix: x=%h y=%h required 3ff 3ff", pix_x, pix_y);
    end
    checks++;
    if (rgb_tft !== 16'h0000) begin
      errors++;
      $display("FAIL reset_rgb: %h required 0000", rgb_tft);
    end
    checks++;
    if (tft_clk !== clk || s_tft_clk !== clk) begin
      errors++;
      $display("FAIL tft_clk: %b/%b required %b", tft_clk, s_tft_clk, clk);
    end
  endtask

  task automatic test_release();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (frame_start !== 1'b1 || tft_bl !== 1'b1 || s_bl !== 1'b1) begin
      errors++;
      $display("FAIL release: fs=%b bl=%b/%b required 1 1/1", frame_start, tft_bl, s_bl);
    end
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b0) begin
      errors++;
      $display("FAIL fs_width: fs=%b at second clock, required 0", frame_start);
    end
  endtask

  task automatic test_small_frame();
    int fs_cnt = 0, last_fs = -1, gap_bad = 0, de_bad = 0;
    while (t < 300) begin
      @(negedge clk);
      if (s_fs) begin
        if ((last_fs >= 0 && t - last_fs != 128) || (t % 128 != 0)) gap_bad++;
        last_fs = t;
        fs_cnt++;
      end
      if (t >= 112 && t < 128 && s_de) de_bad++;
      if (t == 108) begin
        checks++;
        if (s_pix_x !== 11'd7 || s_pix_y !== 11'd3 || s_de !== 1'b1 || s_rgb !== 16'hABCD) begin
          errors++;
          $display("FAIL small_last_line: x=%0d y=%0d de=%b rgb=%h required 7 3 1 abcd",
                   s_pix_x, s_pix_y, s_de, s_rgb);
        end
      end
      if (t == 127) begin
        checks++;
        if (s_vsync !== 1'b0 || s_pix_y !== 11'h3FF || s_fs !== 1'b0) begin
          errors++;
          $display("FAIL small_pre_wrap: vs=%b y=%h fs=%b required 0 3ff 0", s_vsync, s_pix_y, s_fs);
        end
      end
      if (t == 128) begin
        checks++;
        if (s_vsync !== 1'b1 || s_hsync !== 1'b1 || s_fs !== 1'b1) begin
          errors++;
          $display("FAIL small_wrap: vs=%b hs=%b fs=%b required 1 1 1", s_vsync, s_hsync, s_fs);
        end
      end
    end
    checks++;
    if (fs_cnt != 2 || gap_bad != 0) begin
      errors++;
      $display("FAIL small_frame_period: pulses=%0d bad=%0d required 2 0", fs_cnt, gap_bad);
    end
    checks++;
    if (de_bad != 0) begin
      errors++;
      $display("FAIL small_bottom_blank: de high %0d clocks, required 0", de_bad);
    end
  endtask

  task automatic test_sync();
    int hs_hi = 0, vs_hi = 0, r1 = -1, r2 = -1, vs_fall = -1, fs_cnt = 0;
    logic prev_hs, prev_vs;
    prev_hs = hsync;
    prev_vs = vsync;
    while (t < 5300) begin
      @(negedge clk);
      if (t >= 525 && t < 1050 && hsync) hs_hi++;
      if (vsync) vs_hi++;
      if (frame_start) fs_cnt++;
      if (!prev_hs && hsync) begin
        if (r1 < 0) r1 = t;
        else if (r2 < 0) r2 = t;
      end
      if (prev_vs && !vsync && vs_fall < 0) vs_fall = t;
      prev_hs = hsync;
      prev_vs = vsync;
    end
    checks++;
    if (r1 != 525 || r2 - r1 != 525) begin
      errors++;
      $display("FAIL hsync_period: rises at %0d,%0d required 525,1050", r1, r2);
    end
    checks++;
    if (hs_hi != 41) begin
      errors++;
      $display("FAIL hsync_width: %0d required 41", hs_hi);
    end
    checks++;
    if (vs_fall != 5250 || vs_hi != 4949) begin
      errors++;
      $display("FAIL vsync_width: fall at %0d high %0d required 5250 4949", vs_fall, vs_hi);
    end
    checks++;
    if (fs_cnt != 0) begin
      errors++;
      $display("FAIL fs_spurious: %0d pulses mid-frame, required 0", fs_cnt);
    end
  endtask

  task automatic test_vert_top();
    int de_bad = 0, y_bad = 0;
    goto(11 * 525);
    for (int i = 0; i < 525; i++) begin
      if (tft_de) de_bad++;
      if (pix_y !== 11'h3FF) y_bad++;
      @(negedge clk);
    end
    checks++;
    if (de_bad != 0 || y_bad != 0) begin
      errors++;
      $display("FAIL line11_blank: de high %0d, pix_y active %0d, required 0 0", de_bad, y_bad);
    end
  endtask

  task automatic test_line_start();
    int          hs [6];
    logic [10:0] ex [6];
    logic        ed [6];
    logic [15:0] er [6];
    hs = '{41, 42, 43, 44, 90, 91};
    ex = '{11'h3FF, 11'd0, 11'd1, 11'd2, 11'd48, 11'd49};
    ed = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    er = '{16'h0000, 16'h0000, 16'hF800, 16'hF800, 16'hF800, 16'hFC00};
    for (int i = 0; i < 6; i++) begin
      goto(12 * 525 + hs[i]);
      checks++;
      if (pix_x !== ex[i] || tft_de !== ed[i] || rgb_tft !== er[i]
          || pix_y !== ((i == 0) ? 11'h3FF : 11'd0)) begin
        errors++;
        $display("FAIL line12_h%0d: x=%h y=%h de=%b rgb=%h required x=%h de=%b rgb=%h",
                 hs[i], pix_x, pix_y, tft_de, rgb_tft, ex[i], ed[i], er[i]);
      end
    end
  endtask

  task automatic test_line_end();
    goto(12 * 525 + 521);
    checks++;
    if (pix_x !== 11'd479 || tft_de !== 1'b1 || rgb_tft !== 16'hD69A) begin
      errors++;
      $display("FAIL h521: x=%0d de=%b rgb=%h required 479 1 d69a", pix_x, tft_de, rgb_tft);
    end
    goto(12 * 525 + 522);
    checks++;
    if (pix_x !== 11'h3FF || tft_de !== 1'b1 || rgb_tft !== 16'hD69A) begin
      errors++;
      $display("FAIL h522: x=%h de=%b rgb=%h required 3ff 1 d69a", pix_x, tft_de, rgb_tft);
    end
    goto(12 * 525 + 523);
    checks++;
    if (tft_de !== 1'b0 || rgb_tft !== 16'h0000 || pix_x !== 11'h3FF) begin
      errors++;
      $display("FAIL h523: de=%b rgb=%h x=%h required 0 0000 3ff", tft_de, rgb_tft, pix_x);
    end
    goto(13 * 525);
    checks++;
    if (hsync !== 1'b1 || pix_y !== 11'h3FF || tft_de !== 1'b0) begin
      errors++;
      $display("FAIL line13_h0: hs=%b y=%h de=%b required 1 3ff 0", hsync, pix_y, tft_de);
    end
  endtask

  task automatic test_blank_const();
    gen_const = 1'b1;
    goto(13 * 525 + 10);
    checks++;
    if (rgb_tft !== 16'h0000 || hsync !== 1'b1) begin
      errors++;
      $display("FAIL blank_hsync: rgb=%h hs=%b required 0000 1", rgb_tft, hsync);
    end
    goto(13 * 525 + 100);
    checks++;
    if (rgb_tft !== 16'h1234 || pix_x !== 11'd58 || pix_y !== 11'd1) begin
      errors++;
      $display("FAIL const_active: rgb=%h x=%0d y=%0d required 1234 58 1", rgb_tft, pix_x, pix_y);
    end
    goto(13 * 525 + 523);
    checks++;
    if (rgb_tft !== 16'h0000) begin
      errors++;
      $display("FAIL blank_front: rgb=%h required 0000", rgb_tft);
    end
    gen_const = 1'b0;
  endtask

  task automatic test_mid_reset();
    goto(100 * 525 + 300);
    checks++;
    if (tft_de !== 1'b1 || pix_x !== 11'd258 || pix_y !== 11'd88 || hsync !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset: de=%b x=%0d y=%0d hs=%b required 1 258 88 0",
               tft_de, pix_x, pix_y, hsync);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({hsync, vsync, tft_de, tft_bl, frame_start} !== 5'b11000 || rgb_tft !== 16'h0000
        || pix_x !== 11'h3FF || pix_y !== 11'h3FF) begin
      errors++;
      $display("FAIL async_reset: {hs,vs,de,bl,fs}=%b rgb=%h x=%h y=%h required 11000 0000 3ff 3ff",
               {hsync, vsync, tft_de, tft_bl, frame_start}, rgb_tft, pix_x, pix_y);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL restart_fs: fs=%b required 1", frame_start);
    end
    goto(40);
    checks++;
    if (hsync !== 1'b1) begin
      errors++;
      $display("FAIL restart_h40: hs=%b required 1", hsync);
    end
    goto(41);
    checks++;
    if (hsync !== 1'b0) begin
      errors++;
      $display("FAIL restart_h41: hs=%b required 0", hsync);
    end
    goto(12 * 525 + 43);
    checks++;
    if (pix_x !== 11'd1 || tft_de !== 1'b1 || rgb_tft !== 16'hF800 || pix_y !== 11'd0) begin
      errors++;
      $display("FAIL restart_line12: x=%0d y=%0d de=%b rgb=%h required 1 0 1 f800",
               pix_x, pix_y, tft_de, rgb_tft);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_release();
    test_small_frame();
    test_sync();
    test_vert_top();
    test_line_start();
    test_line_end();
    test_blank_const();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tft_timing_ctrl.md
Name: tft_timing_ctrl

Overview:
- Raster timing controller for the 480x272 RGB565 TFT panel on the 9 MHz pixel clock.
- Generates horizontal and vertical counters, sync, data-enable and backlight.
- Issues pixel coordinates pix_x/pix_y to the pixel-generator stage one cycle ahead of display.
- Takes back that stage's registered pix_data and drives it onto the panel bus during the active window.

Parameters:
- H_SYNC, 11'd41, hsync pulse width in clocks
- H_BACK, 11'd2, horizontal back porch
- H_VALID, 11'd480, active pixels per line
- H_FRONT, 11'd2, horizontal front porch
- H_TOTAL, 11'd525, clocks per line (sum of the four above)
- V_SYNC, 11'd10, vsync pulse width in lines
- V_BACK, 11'd2, vertical back porch
- V_VALID, 11'd272, active lines per frame
- V_FRONT, 11'd2, vertical front porch
- V_TOTAL, 11'd286, lines per frame

Ports:
- tft_clk_9m in 1: pixel clock, 9 MHz
- sys_rst_n in 1: reset, asynchronous, active-low
- pix_data in 16: RGB565 from pixel generator, registered there with 1-cycle latency
- pix_x out 11: requested pixel X, 0..479 or 11'h3FF when idle
- pix_y out 11: requested pixel Y, 0..271 or 11'h3FF when idle
- rgb_tft out 16: panel RGB565 data
- hsync out 1: horizontal sync, active high
- vsync out 1: vertical sync, active high
- tft_clk out 1: panel clock, equal to tft_clk_9m
- tft_de out 1: panel data enable
- tft_bl out 1: backlight enable, equal to sys_rst_n
- frame_start out 1: one-cycle pulse at the first clock of each frame

Behaviour:
- Reset: cnt_h=0 and cnt_v=0 asynchronously.
  - Decoded outputs during reset: hsync=1, vsync=1, tft_de=0, rgb_tft=0, pix_x=pix_y=11'h3FF, tft_bl=0, frame_start=0.
  - frame_start is gated by sys_rst_n.
- cnt_h increments every clock and wraps at H_TOTAL-1 to 0.
- cnt_v increments only when cnt_h==H_TOTAL-1 and wraps at V_TOTAL-1 to 0, on the same edge that cnt_h wraps.
- Sync timing:
  - hsync = (cnt_h < H_SYNC).
  - vsync = (cnt_v < V_SYNC).
- Active window:
  - h_act = cnt_h in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VALID), i.e. [43,523).
  - v_act = cnt_v in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VALID), i.e. [12,284).
  - tft_de = h_act & v_act.
- Request window: pix_req = v_act & cnt_h in [42,522), the active window shifted one clock early to absorb the generator's register.
  - When pix_req=1: pix_x = cnt_h-42 and pix_y = cnt_v-12.
  - Otherwise pix_x = pix_y = 11'h3FF, which the generator treats as out-of-range and answers with black.
- Data path: rgb_tft = tft_de ? pix_data : 16'h0000.
  - The pixel requested at clock n is displayed at clock n+1.
- All outputs are combinational decodes of cnt_h/cnt_v; no extra pipeline stages.
- Unsigned 11-bit arithmetic; subtraction is only evaluated inside the window, so it never underflows.
- frame_start = (cnt_h==0 && cnt_v==0); exactly one pulse per 150150 clocks.
- Reset deasserted mid-frame: counters restart from 0,0 on the next edge; no partial line is emitted afterwards.

Test Plan:
- Release reset, run 2 frames -> frame_start pulses exactly 150150 clocks apart; hsync period 525 clocks with high width 41; vsync high width 41*... i.e. 10 lines = 5250 clocks.
- Line 12, cnt_h 41..44 -> pix_x = 3FF,0,1,2; tft_de = 0,0,1,1; rgb_tft at cnt_h=43 equals the pix_data returned for x=0.
- Line end: cnt_h=521 -> pix_x=479; cnt_h=522 -> pix_x=3FF, de=1; cnt_h=523 -> de=0, rgb_tft=0.
- Vertical boundaries: line 11 -> de never 1, pix_y=3FF; line 283 -> pix_y=271; line 284 -> de=0 for the whole line; cnt_v wraps 285->0 while cnt_h wraps 524->0.
- Pair with the colour-bar generator -> rgb_tft at x=0,47 = F800; at x=48 = FC00; at x=479 = D69A; zero outside de. Feed constant pix_data=1234 in blanking -> rgb_tft=0.
- Assert sys_rst_n low at cnt_h=300, cnt_v=100 -> outputs go to reset values immediately; after release the first frame_start occurs on the first edge and full timing repeats.
